// File: rtl/pipelined_adder_pkg.sv
// Shared configuration helpers and per-stage control payload for the pipelined adder.
// Fields for the optional ADDER_OVF_DETECT_EN build ride alongside each beat.
package adder_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_CHUNK  = 8;
   localparam int DEF_STAGES = DEF_WIDTH / DEF_CHUNK;

   function automatic int stages_of(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic bit cfg_ok(input int width, input int chunk);
      return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

   typedef struct packed {
      logic valid;
      logic cin;
`ifdef ADDER_OVF_DETECT_EN
      logic a_msb;
      logic b_msb;
`endif
   } stage_ctl_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bus of the pipelined adder: valid/ready on both sides.
interface pipelined_adder_if #(
   parameter int WIDTH = adder_pkg::DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, c, out_ready,
      output in_ready, out_valid, sum, carry, ovf
   );

   modport master (
      output in_valid, a, b, c, out_ready,
      input  in_ready, out_valid, sum, carry, ovf
   );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One ripple stage: adds the low CHUNK bits of the remaining operands plus carry-in, 1-cycle registered.
// Holds data and valid while i_stall is high; data registers only load on a valid beat.
module adder_stage
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall,
   input  stage_ctl_t       i_ctl,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_sum,
   output stage_ctl_t       o_ctl,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [WIDTH-1:0] o_sum
);

   stage_ctl_t       r_ctl;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CHUNK:0]   w_add;

   assign w_add = {1'b0, i_a[CHUNK-1:0]} + {1'b0, i_b[CHUNK-1:0]} + (CHUNK+1)'(i_ctl.cin);

   // Operands shift down one chunk per stage; finished chunks enter the sum from the top,
   // so after the last stage the sum is in natural bit order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ctl <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_sum <= '0;
      end else if (!i_stall) begin
         r_ctl.valid <= i_ctl.valid;
         if (i_ctl.valid) begin
            r_ctl.cin <= w_add[CHUNK];
`ifdef ADDER_OVF_DETECT_EN
            r_ctl.a_msb <= i_ctl.a_msb;
            r_ctl.b_msb <= i_ctl.b_msb;
`endif
            r_a   <= i_a >> CHUNK;
            r_b   <= i_b >> CHUNK;
            r_sum <= WIDTH'({w_add[CHUNK-1:0], i_sum} >> CHUNK);
         end
      end
   end

   assign o_ctl = r_ctl;
   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_sum = r_sum;

endmodule

// File: rtl/pipelined_adder.sv
// Registered WIDTH-bit adder, CHUNK bits per stage; latency WIDTH/CHUNK cycles, 1 beat/cycle.
// Full back-pressure: in_ready = !(out_valid && !out_ready); ADDER_OVF_DETECT_EN adds signed overflow.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic               clk,
   input  logic               rst,
   pipelined_adder_if.slave   bus
);

   localparam int STAGES = stages_of(WIDTH, CHUNK);

   if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
   end
   if ($bits(bus.a) != WIDTH) begin : g_bad_bus
      $error("pipelined_adder: interface WIDTH does not match module WIDTH");
   end

   stage_ctl_t       r_ctl0;
   logic [WIDTH-1:0] r_a0;
   logic [WIDTH-1:0] r_b0;
   logic             w_stall;

   stage_ctl_t       w_ctl [STAGES+1];
   logic [WIDTH-1:0] w_a   [STAGES+1];
   logic [WIDTH-1:0] w_b   [STAGES+1];
   logic [WIDTH-1:0] w_sum [STAGES+1];
   logic             w_unused_tail;

   assign w_stall      = w_ctl[STAGES].valid && !bus.out_ready;
   assign bus.in_ready = !w_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ctl0 <= '0;
         r_a0   <= '0;
         r_b0   <= '0;
      end else if (!w_stall) begin
         r_ctl0.valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_ctl0.cin <= bus.c;
`ifdef ADDER_OVF_DETECT_EN
            r_ctl0.a_msb <= bus.a[WIDTH-1];
            r_ctl0.b_msb <= bus.b[WIDTH-1];
`endif
            r_a0 <= bus.a;
            r_b0 <= bus.b;
         end
      end
   end

   assign w_ctl[0] = r_ctl0;
   assign w_a[0]   = r_a0;
   assign w_b[0]   = r_b0;
   assign w_sum[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_stall (w_stall),
         .i_ctl   (w_ctl[k]),
         .i_a     (w_a[k]),
         .i_b     (w_b[k]),
         .i_sum   (w_sum[k]),
         .o_ctl   (w_ctl[k+1]),
         .o_a     (w_a[k+1]),
         .o_b     (w_b[k+1]),
         .o_sum   (w_sum[k+1])
      );
   end

   // Operand remainders are fully consumed by the last stage.
   assign w_unused_tail = ^{w_a[STAGES], w_b[STAGES]};

   assign bus.out_valid = w_ctl[STAGES].valid;
   assign bus.sum       = w_sum[STAGES];
   assign bus.carry     = w_ctl[STAGES].cin;
`ifdef ADDER_OVF_DETECT_EN
   assign bus.ovf = w_ctl[STAGES].valid
                 && (w_ctl[STAGES].a_msb == w_ctl[STAGES].b_msb)
                 && (w_sum[STAGES][WIDTH-1] != w_ctl[STAGES].a_msb);
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed table plus corner sequences on a 32/8 instance, random streaming on 16/4 and 8/8 instances.
module tb_pipelined_adder;

   localparam bit OVF_ON =
`ifdef ADDER_OVF_DETECT_EN
      1'b1;
`else
      1'b0;
`endif
   localparam int NRND = 10000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(32)) bus32 ();
   pipelined_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_adder_if #(.WIDTH(8))  bus8  ();

   pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   pipelined_adder #(.WIDTH(8),  .CHUNK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int sent;
      int got;
      int seen;
      logic [32:0] exp_q [$];
      logic [63:0] exp;

      tbl[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
      tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      tbl[5] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
      tbl[6] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0};
      tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[8] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
      tbl[9] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};

      // Reset held 3 cycles with traffic offered
      bus32.in_valid = 1'b1; bus32.a = 32'h5; bus32.b = 32'h6; bus32.c = 1'b1; bus32.out_ready = 1'b1;
      bus16.in_valid = 1'b1; bus16.a = 16'h5; bus16.b = 16'h6; bus16.c = 1'b0; bus16.out_ready = 1'b1;
      bus8.in_valid  = 1'b1; bus8.a  = 8'h5;  bus8.b  = 8'h6;  bus8.c  = 1'b0; bus8.out_ready  = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_valid", 64'(bus32.out_valid), 64'(0));
      check("rst_sum",       64'(bus32.sum),       64'(0));
      check("rst_carry",     64'(bus32.carry),     64'(0));
      check("rst_ovf",       64'(bus32.ovf),       64'(0));
      check("rst_out_valid16", 64'(bus16.out_valid), 64'(0));
      check("rst_out_valid8",  64'(bus8.out_valid),  64'(0));
      rst = 1'b1;
      bus32.in_valid = 1'b0; bus16.in_valid = 1'b0; bus8.in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("rel_in_ready",  64'(bus32.in_ready),  64'(1));
      check("rel_out_valid", 64'(bus32.out_valid), 64'(0));

      // Latency: accepted at edge 0, visible after edge 4
      bus32.a = 32'h1; bus32.b = 32'h2; bus32.c = 1'b0; bus32.in_valid = 1'b1;
      check("lat_in_ready", 64'(bus32.in_ready), 64'(1));
      tick();
      bus32.in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         @(negedge clk);
         check("lat_out_valid", 64'(bus32.out_valid), 64'(k == 4));
      end
      check("lat_sum",   64'(bus32.sum),   64'(32'h3));
      check("lat_carry", 64'(bus32.carry), 64'(0));

      for (int i = 0; i < 10; i++) begin
         bus32.a = tbl[i].a; bus32.b = tbl[i].b; bus32.c = tbl[i].c; bus32.in_valid = 1'b1;
         tick();
         bus32.in_valid = 1'b0;
         repeat (4) tick();
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 64'(bus32.out_valid), 64'(1));
         check($sformatf("vec%0d_sum", i),   64'(bus32.sum),       64'(tbl[i].sum));
         check($sformatf("vec%0d_carry", i), 64'(bus32.carry),     64'(tbl[i].carry));
         check($sformatf("vec%0d_ovf", i),   64'(bus32.ovf),       64'(tbl[i].ovf & OVF_ON));
      end
      tick();

      // Back-pressure: 10 beats, consumer stalls on cycles 5-9
      cyc = 0; sent = 0; got = 0;
      while (got < 10 && cyc < 200) begin
         bus32.out_ready = !(cyc >= 5 && cyc <= 9);
         bus32.in_valid  = (sent < 10);
         bus32.a = 32'(sent); bus32.b = 32'(100 * sent); bus32.c = sent[0];
         @(negedge clk);
         if (bus32.out_valid && !bus32.out_ready)
            check("bp_in_ready_stalled", 64'(bus32.in_ready), 64'(0));
         if (bus32.in_valid && bus32.in_ready) begin
            exp_q.push_back(33'(sent) + 33'(100 * sent) + 33'(sent & 1));
            sent++;
         end
         if (bus32.out_valid && bus32.out_ready) begin
            exp = (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : {1'b1, 63'b0};
            check("bp_result", 64'({bus32.carry, bus32.sum}), exp);
            got++;
         end
         tick();
         cyc++;
      end
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      check("bp_count", 64'(got), 64'(10));
      @(negedge clk);
      check("bp_no_dup", 64'(bus32.out_valid), 64'(0));
      tick();

      // Mid-run reset with 3 beats in flight
      for (int i = 0; i < 3; i++) begin
         bus32.a = 32'h1111_1111 * 32'(i + 1); bus32.b = 32'h1; bus32.c = 1'b0; bus32.in_valid = 1'b1;
         tick();
      end
      bus32.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus32.out_valid) seen++;
         tick();
      end
      check("mrst_quiet", 64'(seen), 64'(0));
      bus32.a = 32'h0F0F_0F0F; bus32.b = 32'h0101_0101; bus32.c = 1'b1; bus32.in_valid = 1'b1;
      tick();
      bus32.in_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("mrst_valid", 64'(bus32.out_valid), 64'(1));
      check("mrst_sum",   64'(bus32.sum),       64'(32'h1010_1011));
      check("mrst_carry", 64'(bus32.carry),     64'(0));
      tick();

      // Random streaming on the narrow configurations, run concurrently
      fork
         begin : rnd16
            int c16 = 0; int s16 = 0; int g16 = 0;
            logic [16:0] q16 [$];
            logic [63:0] e16;
            while (g16 < NRND && c16 < 60000) begin
               bus16.out_ready = ($urandom_range(3) != 0);
               bus16.in_valid  = (s16 < NRND) && ($urandom_range(3) != 0);
               bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.c = 1'($urandom);
               @(negedge clk);
               if (bus16.in_valid && bus16.in_ready) begin
                  q16.push_back(17'(bus16.a) + 17'(bus16.b) + 17'(bus16.c));
                  s16++;
               end
               if (bus16.out_valid && bus16.out_ready) begin
                  e16 = (q16.size() != 0) ? 64'(q16.pop_front()) : {1'b1, 63'b0};
                  check("rnd16_result", 64'({bus16.carry, bus16.sum}), e16);
                  g16++;
               end
               tick();
               c16++;
            end
            check("rnd16_count", 64'(g16), 64'(NRND));
         end
         begin : rnd8
            int c8 = 0; int s8 = 0; int g8 = 0;
            logic [8:0] q8 [$];
            logic [63:0] e8;
            while (g8 < NRND && c8 < 60000) begin
               bus8.out_ready = ($urandom_range(3) != 0);
               bus8.in_valid  = (s8 < NRND) && ($urandom_range(3) != 0);
               bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c = 1'($urandom);
               @(negedge clk);
               if (bus8.in_valid && bus8.in_ready) begin
                  q8.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.c));
                  s8++;
               end
               if (bus8.out_valid && bus8.out_ready) begin
                  e8 = (q8.size() != 0) ? 64'(q8.pop_front()) : {1'b1, 63'b0};
                  check("rnd8_result", 64'({bus8.carry, bus8.sum}), e8);
                  g8++;
               end
               tick();
               c8++;
            end
            check("rnd8_count", 64'(g8), 64'(NRND));
         end
      join

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
